// File: rtl/switch_rr_allocator.sv
// rtl/switch_rr_allocator.sv - per-output round-robin switch allocator with held grants
module switch_rr_allocator #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [INPUTS-1:0]                       reqValid,
  input  logic [INPUTS-1:0][REQUEST_WIDTH-1:0]    reqDest,
  input  logic [INPUTS-1:0]                       reqRelieve,
  output logic [INPUTS-1:0]                       grant,
  output logic [INPUTS-1:0]                       portReserved,
  output logic [OUTPUTS-1:0][REQUEST_WIDTH-1:0]   routeSelect,
  output logic [OUTPUTS-1:0]                      outputBusy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q [OUTPUTS];
  state_t                   state_d [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] owner_q [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] owner_d [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] ptr_q   [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] ptr_d   [OUTPUTS];

  logic [INPUTS-1:0]                     grant_d;
  logic [INPUTS-1:0]                     reserved_d;
  logic [OUTPUTS-1:0]                    busy_d;
  logic [OUTPUTS-1:0][REQUEST_WIDTH-1:0] route_d;

  always_comb begin
    int   idx;
    int   win;
    logic found;
    grant_d    = '0;
    reserved_d = portReserved;
    busy_d     = outputBusy;
    route_d    = routeSelect;
    idx        = 0;
    win        = 0;
    found      = 1'b0;
    for (int o = 0; o < OUTPUTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      win        = 0;
      case (state_q[o])
        IDLE: begin
          // Scan from the pointer; reserved inputs are never candidates,
          // which also keeps a releasing input from winning on its release edge.
          for (int k = 0; k < INPUTS; k++) begin
            idx = (int'(ptr_q[o]) + k) % INPUTS;
            if (!found && reqValid[idx] && !portReserved[idx] &&
                int'(reqDest[idx]) == o) begin
              found = 1'b1;
              win   = idx;
            end
          end
          if (found) begin
            state_d[o]      = BUSY;
            owner_d[o]      = REQUEST_WIDTH'(win);
            route_d[o]      = REQUEST_WIDTH'(win);
            busy_d[o]       = 1'b1;
            reserved_d[win] = 1'b1;
            grant_d[win]    = 1'b1;
          end
        end
        BUSY: begin
          if (reqRelieve[owner_q[o]]) begin
            state_d[o]               = IDLE;
            busy_d[o]                = 1'b0;
            reserved_d[owner_q[o]]   = 1'b0;
            ptr_d[o]                 = REQUEST_WIDTH'((int'(owner_q[o]) + 1) % INPUTS);
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      portReserved <= '0;
      routeSelect  <= '0;
      outputBusy   <= '0;
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      grant        <= grant_d;
      portReserved <= reserved_d;
      routeSelect  <= route_d;
      outputBusy   <= busy_d;
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule

// File: doc/switch_rr_allocator.md
Name: switch_rr_allocator

Overview:
- Round-robin switch allocator for the mesh router crossbar. It replaces fixed-priority conflict resolution with per-output fair arbitration.
- Input ports request one output port each. Every output port grants one input at a time and holds that grant until the input relieves it.
- Outputs drive the crossbar routeSelect and outputBusy directly and return grant/reserved status to the input buffers.

Parameters:
- INPUTS, 4, number of requesting input ports.
- OUTPUTS, 4, number of output ports. Must be <= 2^REQUEST_WIDTH.
- REQUEST_WIDTH, 2, width of an output-port or input-port index. Must be >= clog2(INPUTS) and >= clog2(OUTPUTS).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- reqValid  input  [INPUTS]  input i requests output reqDest[i].
- reqDest  input  [INPUTS][REQUEST_WIDTH]  requested output index; must be stable while reqValid is high and no grant has been received.
- reqRelieve  input  [INPUTS]  input i releases the output it owns (tail flit sent).
- grant  output  [INPUTS]  one-cycle pulse: input i has just won its output.
- portReserved  output  [INPUTS]  level: input i currently owns an output.
- routeSelect  output  [OUTPUTS][REQUEST_WIDTH]  owning input index per output, fed to the crossbar mux.
- outputBusy  output  [OUTPUTS]  output o is currently owned.

Behaviour:
- Reset (rst=1 at posedge): all outputs go to 0, all per-output FSMs go to IDLE, all RR pointers and owner registers go to 0. A reset mid-transfer drops every reservation at that edge, with no grant or relieve side effects.
- Each output o has a 2-state FSM (IDLE, BUSY), an owner register owner[o] and a pointer ptr[o], both REQUEST_WIDTH wide.
- Candidate set in cycle t: cand[o][i] = reqValid[i] & (reqDest[i]==o) & ~portReserved[i].
  - An input that already owns an output is never a candidate.
  - reqDest >= OUTPUTS matches no output and is ignored; the input simply waits forever.
- IDLE behaviour:
  - If any cand[o][i] is set, the winner is the first set index scanning ptr[o], ptr[o]+1, ... modulo INPUTS.
  - At the next edge: state becomes BUSY, owner[o] and routeSelect[o] take the winner, outputBusy[o]=1, portReserved[winner]=1, and grant[winner]=1 for exactly that one cycle.
  - Grant latency is therefore one cycle from a valid request seen in IDLE.
- BUSY behaviour:
  - The FSM stays BUSY until reqRelieve[owner[o]]=1 is sampled.
  - At that edge: state becomes IDLE, outputBusy[o]=0, portReserved[owner]=0, and ptr[o]=(owner[o]+1) mod INPUTS.
  - reqRelieve from a non-owner input is ignored.
  - reqRelieve from an input that owns nothing is ignored.
- No re-grant on the release edge: an output spends at least one cycle in IDLE between owners. Minimum owner-to-owner gap is 2 cycles (release edge, then grant edge).
- routeSelect[o] holds its last value after release. It changes only on a new grant.
- If reqValid stays high after a grant, it has no effect while the input is reserved. If reqValid is still high after release, the input re-competes from IDLE at the rotated pointer priority.
- Outputs arbitrate independently. Different outputs may grant on the same edge, so multiple grant bits can pulse simultaneously.
- An input wins at most one output, because reqDest is single-valued.
- If reqDest changes before a grant, arbitration uses the current value. Stability is the requester's responsibility.
- If reqValid is withdrawn before the grant, no grant is issued.
- All outputs are registered. No combinational path exists from any input to any output.
- Invariants (asserted in verification):
  - grant is one-hot per output.
  - popcount(portReserved) == popcount(outputBusy).
  - portReserved[i] implies exactly one o with outputBusy[o] & routeSelect[o]==i.

Test Plan:
- Single request: input 2 requests output 1 at t0 -> at t1 grant[2] pulses, routeSelect[1]=2, outputBusy[1]=1, portReserved[2]=1. reqRelieve[2] at t5 -> t6 outputBusy[1]=0, portReserved[2]=0, ptr[1]=3.
- Full conflict: all 4 inputs request output 0 continuously, each relieving 3 cycles after its grant -> grant order 0,1,2,3,0. Each release is followed by exactly one IDLE cycle.
- Non-owner relieve: input 1 owns output 3 while input 0 pulses reqRelieve -> outputBusy[3] stays 1 and routeSelect[3] stays 1.
- Same-edge release and re-request: input 1 relieves output 2 while inputs 1 and 3 request output 2 -> the IDLE cycle occurs, then input 3 is granted (ptr=2 scans 2,3), not input 1.
- Parallel outputs: inputs 0,1,2,3 request outputs 3,2,1,0 in the same cycle -> all four grant bits pulse together. routeSelect={0,1,2,3} for outputs {3,2,1,0}, outputBusy=4'b1111.
- Reset mid-operation: rst=1 while 3 outputs are busy -> next cycle all outputs are 0. Requests held through reset get a grant 1 cycle after rst falls, with ptr=0 priority (lowest index wins).
